apb_slave_regmem: RTL and testbench
===================================

// Module: apb_slave_regmem
// PURPOSE
// APB3 completer that consumes the transfers driven onto the master interface (PSELx/PENABLE/PWRITE/PADDR/PWDATA)
// and returns PRDATA/PREADY/PSLVERR. Backs a word-addressed register memory, inserts programmable wait states,
// flags bad addresses via PSLVERR and counts master protocol violations. Serves as the DUT-side target for master-agent tests.
// PARAMETERS
// ADDR_W   8   PADDR width (byte address)
// DATA_W   32  PWDATA/PRDATA width
// DEPTH    64  number of DATA_W words; valid byte addresses 0 .. DEPTH*4-4, word aligned
// PORTS
// PCLK       in   1        APB clock; all logic on rising edge
// PRESET     in   1        synchronous, active-high reset
// PSELx      in   1        slave select
// PENABLE    in   1        access phase
// PWRITE     in   1        1=write, 0=read
// PADDR      in   ADDR_W   byte address
// PWDATA     in   DATA_W   write data
// PRDATA     out  DATA_W   read data, valid while PREADY=1 on a read
// PREADY     out  1        transfer completes on an edge sampling PSELx&PENABLE&PREADY
// PSLVERR    out  1        error for current transfer, valid only while PREADY=1
// wait_cfg   in   4        wait states per transfer (0-15), sampled at setup edge
// err_count  out  8        saturating count of protocol violations
// BEHAVIOUR
// - Reset: PRDATA=0, PREADY=0, PSLVERR=0, err_count=0, all memory words=0, state=IDLE. Reset in any state: next state IDLE,
//   pending write discarded, outputs return to reset values.
// - All outputs registered. FSM states IDLE, ACC_WAIT, ACC_DONE.
// - IDLE, edge sampling PSELx=1 & PENABLE=0 (setup): latch PADDR/PWRITE/PWDATA; cnt<=wait_cfg;
//   err = PADDR[1:0]!=0 or PADDR[ADDR_W-1:2]>=DEPTH; on read PRDATA<=err?0:mem[idx].
//   wait_cfg==0 -> ACC_DONE, PREADY<=1, PSLVERR<=err; else -> ACC_WAIT, PREADY<=0.
// - ACC_WAIT: each edge with PSELx&PENABLE: cnt--; at edge where cnt==1 -> ACC_DONE, PREADY<=1, PSLVERR<=err.
//   Latency setup-edge to completion edge = wait_cfg+1 cycles (zero-wait: completes 1st access cycle).
// - ACC_DONE: edge with PSELx&PENABLE: commit write mem[idx]<=PWDATA_latched if PWRITE & !err;
//   PREADY<=0, PSLVERR<=0, PRDATA held; -> IDLE. Back-to-back setup next cycle is accepted from IDLE.
// - Erroring writes never modify memory; erroring reads return 0.
// - Protocol violations (err_count+1, saturates at 255):
//   a) IDLE sees PSELx=1 & PENABLE=1 (access without setup): ignored, stays IDLE, PREADY stays 0.
//   b) ACC_WAIT/ACC_DONE sees PSELx=0 or PENABLE=0 (abort): -> IDLE, no write, PREADY/PSLVERR<=0.
// - PADDR/PWRITE/PWDATA changes during access are not checked; latched setup values are used.
// - Write then read of same address back-to-back returns new data (write commits before next setup edge).
// STRUCTURE
// - Package apb_pkg: typedef enum logic[1:0] {IDLE, ACC_WAIT, ACC_DONE} apb_slv_state_e; localparams for default
//   ADDR_W/DATA_W/DEPTH; function addr_err(addr) shared with the scoreboard reference model.
// - Sub-module apb_slave_mem_array: DEPTH x DATA_W storage, sync write, async read, sync clear on PRESET.
// - Top: FSM, wait counter, latches, error counter.
// TESTING
// - Reset: assert PRESET 2 cycles -> PREADY=0, PSLVERR=0, PRDATA=0, err_count=0; read addr 0x10 returns 0.
// - Zero-wait: wait_cfg=0, write 0xDEADBEEF @0x04, read @0x04 -> PREADY high 1st access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
// - Wait states: wait_cfg=3, read @0x08 -> PREADY low 3 access cycles, high on 4th; completion 4 cycles after setup edge.
// - Errors: write 0x1234 @0x02 and @0xFC (DEPTH=64 -> >=0x100 invalid, 0xFC valid) plus read @0x100 w/ ADDR_W=9
//   -> PSLVERR=1 for 0x02/0x100, mem unchanged, read data 0; 0xFC write succeeds.
// - Protocol: PENABLE=1 without setup -> err_count=1, no PREADY; deassert PSELx mid-ACC_WAIT on write 0x55@0x0C
//   -> err_count=2, mem[3] unchanged; 300 violations -> err_count=255.
// - Reset mid-transfer: PRESET during ACC_WAIT of write @0x10 -> IDLE next edge, mem[4]=0, next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-memory completer.
package apb_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_DEPTH  = 64;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACC_WAIT = 2'd1,
      ACC_DONE = 2'd2
   } apb_slv_state_e;

   // A byte address is bad when it is not word aligned or its word index lies past the array.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage : apb_pkg

// File: rtl/apb_slave_mem_array.sv
// Word storage behind the APB completer: synchronous write, asynchronous read, synchronous clear.
module apb_slave_mem_array #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Clear every word on reset, otherwise commit the requested write.
   always_ff @(posedge clk_i) begin
      // NOTE: this memory is reset word by word because software relies on reading zeros after reset;
      // that forces flops instead of a RAM macro, which is acceptable at this depth.
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : apb_slave_mem_array

// File: rtl/apb_slave_regmem.sv
// APB3 completer backed by a word-addressed register memory, with programmable wait states,
// address error reporting and a saturating protocol-violation counter.
module apb_slave_regmem
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSELx,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   input  logic [3:0]        wait_cfg,
   output logic [7:0]        err_count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   apb_slv_state_e    state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic [7:0]        errcnt_q, errcnt_d;

   logic              setup_err;
   logic              viol;
   logic              mem_we;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_data;

   assign setup_err = addr_err(32'(PADDR), DEPTH);
   // Out-of-range indices may alias here; their data is discarded because setup_err forces zero.
   assign rd_idx    = PADDR[IDX_W+1:2];

   apb_slave_mem_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk_i   (PCLK),
      .rst_i   (PRESET),
      .we_i    (mem_we),
      .waddr_i (idx_q),
      .wdata_i (wdata_q),
      .raddr_i (rd_idx),
      .rdata_o (rd_data)
   );

   // Transfer sequencing: setup capture, wait countdown, completion/commit and violation detection.
   always_comb begin
      // NOTE: every value driven here gets a default first, so no path through the case can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      viol      = 1'b0;
      mem_we    = 1'b0;

      case (state_q)
         IDLE: begin
            if (PSELx && !PENABLE) begin
               idx_d   = rd_idx;
               write_d = PWRITE;
               wdata_d = PWDATA;
               cnt_d   = wait_cfg;
               err_d   = setup_err;
               if (!PWRITE) begin
                  prdata_d = setup_err ? '0 : rd_data;
               end
               if (wait_cfg == 4'd0) begin
                  state_d   = ACC_DONE;
                  pready_d  = 1'b1;
                  pslverr_d = setup_err;
               end else begin
                  state_d  = ACC_WAIT;
                  pready_d = 1'b0;
               end
            end else if (PSELx && PENABLE) begin
               // Access phase without a setup phase: ignored apart from being counted.
               viol = 1'b1;
            end
         end

         ACC_WAIT: begin
            if (PSELx && PENABLE) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d   = ACC_DONE;
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
               end
            end else begin
               viol      = 1'b1;
               state_d   = IDLE;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
            end
         end

         ACC_DONE: begin
            if (PSELx && PENABLE) begin
               mem_we = write_q && !err_q;
            end else begin
               viol = 1'b1;
            end
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
         end

         default: begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
         end
      endcase
   end

   // Violation counter saturates rather than wrapping.
   always_comb begin
      errcnt_d = errcnt_q;
      if (viol && (errcnt_q != 8'hFF)) begin
         errcnt_d = errcnt_q + 8'd1;
      end
   end

   // State and output registers; reset abandons any pending transfer.
   always_ff @(posedge PCLK) begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      if (PRESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         errcnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         errcnt_q  <= errcnt_d;
      end
   end

   assign PRDATA    = prdata_q;
   assign PREADY    = pready_q;
   assign PSLVERR   = pslverr_q;
   assign err_count = errcnt_q;

endmodule : apb_slave_regmem

// File: tb/tb_apb_slave_regmem.sv
// Self-checking bench for apb_slave_regmem: directed vector table, protocol corner sequences,
// and randomized transfers checked against an array-based memory model.
module tb_apb_slave_regmem;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 64;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              PSELx;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;
   logic [3:0]        wait_cfg;
   logic [7:0]        err_count;

   apb_slave_regmem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .PSELx     (PSELx),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .wait_cfg  (wait_cfg),
      .err_count (err_count)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      bit          wr;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  ws;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   int n_chk = 0;
   int n_err = 0;

   // Reference model: plain word array plus a violation tally.
   logic [31:0] model_mem [DEPTH];
   int          model_viol = 0;

   function automatic bit model_bad(input int unsigned a);
      return ((a % 4) != 0) || (a >= DEPTH * 4);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
      model_viol = 0;
   endtask

   task automatic model_apply(input bit wr, input logic [8:0] addr, input logic [31:0] wd);
      if (wr && !model_bad(int'(addr))) model_mem[int'(addr) / 4] = wd;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   // One complete APB transfer; signals that the completer must ignore are scrambled during access.
   task automatic apb_xfer(input bit wr, input logic [8:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, output logic [31:0] rd, output logic err,
                           output int lat);
      PSELx    = 1'b1;
      PENABLE  = 1'b0;
      PWRITE   = wr;
      PADDR    = addr;
      PWDATA   = wd;
      wait_cfg = ws;
      step();
      PENABLE  = 1'b1;
      PADDR    = 9'($urandom);
      PWDATA   = $urandom;
      PWRITE   = 1'($urandom);
      wait_cfg = 4'($urandom);
      lat = 1;
      while ((PREADY !== 1'b1) && (lat <= 20)) begin
         step();
         lat++;
      end
      rd  = PRDATA;
      err = PSLVERR;
      step();
      PSELx   = 1'b0;
      PENABLE = 1'b0;
   endtask

   task automatic do_and_check(input string name, input bit wr, input logic [8:0] addr,
                               input logic [31:0] wd, input logic [3:0] ws);
      logic [31:0] rd;
      logic        err;
      int          lat;
      bit          bad;
      logic [31:0] exp_rd;
      bad    = model_bad(int'(addr));
      exp_rd = '0;
      if (!bad) exp_rd = model_mem[int'(addr) / 4];
      apb_xfer(wr, addr, wd, ws, rd, err, lat);
      check({name, "_lat"}, 32'(lat), 32'(ws) + 32'd1);
      check({name, "_slverr"}, 32'(err), 32'(bad));
      if (!wr) check({name, "_rdata"}, rd, exp_rd);
      model_apply(wr, addr, wd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        err;
      int          lat;
      logic [8:0]  a;

      vecs[0]  = '{1'b1, 9'h004, 32'hDEADBEEF, 4'd0,  32'h0,        1'b0};
      vecs[1]  = '{1'b0, 9'h004, 32'h0,        4'd0,  32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b0, 9'h008, 32'h0,        4'd3,  32'h0,        1'b0};
      vecs[3]  = '{1'b1, 9'h002, 32'h00001234, 4'd0,  32'h0,        1'b1};
      vecs[4]  = '{1'b1, 9'h0FC, 32'h00001234, 4'd1,  32'h0,        1'b0};
      vecs[5]  = '{1'b1, 9'h100, 32'h00001234, 4'd0,  32'h0,        1'b1};
      vecs[6]  = '{1'b0, 9'h100, 32'h0,        4'd2,  32'h0,        1'b1};
      vecs[7]  = '{1'b0, 9'h000, 32'h0,        4'd0,  32'h0,        1'b0};
      vecs[8]  = '{1'b0, 9'h0FC, 32'h0,        4'd0,  32'h00001234, 1'b0};
      vecs[9]  = '{1'b0, 9'h006, 32'h0,        4'd0,  32'h0,        1'b1};
      vecs[10] = '{1'b1, 9'h008, 32'hA5A50F0F, 4'd15, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 9'h008, 32'h0,        4'd4,  32'hA5A50F0F, 1'b0};

      PRESET   = 1'b1;
      PSELx    = 1'b0;
      PENABLE  = 1'b0;
      PWRITE   = 1'b0;
      PADDR    = '0;
      PWDATA   = '0;
      wait_cfg = '0;
      model_clear();

      // Reset state after two reset cycles.
      step();
      step();
      check("rst_pready", 32'(PREADY), 32'd0);
      check("rst_pslverr", 32'(PSLVERR), 32'd0);
      check("rst_prdata", PRDATA, 32'h0);
      check("rst_errcnt", 32'(err_count), 32'd0);
      PRESET = 1'b0;
      do_and_check("rst_rd10", 1'b0, 9'h010, 32'h0, 4'd0);

      // Directed vectors with hand-computed expectations.
      for (int i = 0; i < NV; i++) begin
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ws, rd, err, lat);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].ws) + 32'd1);
         check($sformatf("vec%0d_slverr", i), 32'(err), 32'(vecs[i].exp_err));
         if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      end

      // Access phase without setup: counted, ignored, no PREADY.
      PSELx   = 1'b1;
      PENABLE = 1'b1;
      step();
      model_viol++;
      check("noset_pready", 32'(PREADY), 32'd0);
      check("noset_errcnt", 32'(err_count), 32'(model_viol));
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      step();
      check("noset_idle_pready", 32'(PREADY), 32'd0);

      // Abort a waited write mid-ACC_WAIT: no commit.
      PSELx    = 1'b1;
      PENABLE  = 1'b0;
      PWRITE   = 1'b1;
      PADDR    = 9'h00C;
      PWDATA   = 32'h00000055;
      wait_cfg = 4'd3;
      step();
      PENABLE = 1'b1;
      step();
      check("abort_wait_pready", 32'(PREADY), 32'd0);
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      step();
      model_viol++;
      check("abort_errcnt", 32'(err_count), 32'd2);
      check("abort_pready", 32'(PREADY), 32'd0);
      do_and_check("abort_rd0c", 1'b0, 9'h00C, 32'h0, 4'd0);

      // Flood of violations saturates the counter.
      PSELx   = 1'b1;
      PENABLE = 1'b1;
      for (int i = 0; i < 298; i++) step();
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      step();
      check("sat_errcnt", 32'(err_count), 32'd255);
      do_and_check("sat_rdfc", 1'b0, 9'h0FC, 32'h0, 4'd1);

      // Reset during ACC_WAIT of a write: discarded, outputs and memory cleared.
      PSELx    = 1'b1;
      PENABLE  = 1'b0;
      PWRITE   = 1'b1;
      PADDR    = 9'h010;
      PWDATA   = 32'hCAFEF00D;
      wait_cfg = 4'd5;
      step();
      PENABLE = 1'b1;
      step();
      PRESET = 1'b1;
      step();
      check("mrst_pready", 32'(PREADY), 32'd0);
      check("mrst_pslverr", 32'(PSLVERR), 32'd0);
      check("mrst_prdata", PRDATA, 32'h0);
      check("mrst_errcnt", 32'(err_count), 32'd0);
      PRESET  = 1'b0;
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      model_clear();
      step();
      do_and_check("mrst_rd10", 1'b0, 9'h010, 32'h0, 4'd2);
      do_and_check("mrst_wr10", 1'b1, 9'h010, 32'h13579BDF, 4'd0);
      do_and_check("mrst_rd10b", 1'b0, 9'h010, 32'h0, 4'd0);
      do_and_check("mrst_rd04", 1'b0, 9'h004, 32'h0, 4'd0);

      // Randomized back-to-back traffic against the model.
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 1) == 1) a = 9'($urandom_range(0, 63) * 4);
         else                           a = 9'($urandom_range(0, 511));
         do_and_check($sformatf("rnd%0d", i), 1'($urandom), a, $urandom,
                      4'($urandom_range(0, 4)));
      end
      check("rnd_errcnt", 32'(err_count), 32'(model_viol));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_apb_slave_regmem
